// File: rtl/iq_freelist_pkg.sv
// Shared sizing, types and FSM encoding for the issue-queue free-list controller.
package iq_freelist_pkg;

  localparam int unsigned DEF_RPORT = 4;
  localparam int unsigned DEF_WPORT = 4;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_INDEX = 4;

  typedef logic [DEF_INDEX-1:0] iq_idx_t;
  typedef logic [DEF_INDEX:0]   cnt_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/iq_freelist_compact.sv
// Packs the valid freed-entry lanes into dense low lanes, preserving lane order.
module iq_freelist_compact
  import iq_freelist_pkg::*;
#(
  parameter int unsigned WPORT = DEF_WPORT,
  parameter int unsigned INDEX = DEF_INDEX,
  parameter int unsigned CNTW  = $clog2(DEF_WPORT + 1)
) (
  input  logic [WPORT-1:0]       valid_i,
  input  logic [WPORT*INDEX-1:0] entry_i,
  output logic [WPORT-1:0]       valid_o,
  output logic [WPORT*INDEX-1:0] entry_o,
  output logic [CNTW-1:0]        count_o
);

  int unsigned seen;

  // seen is the running prefix count: input lane i lands on output lane seen
  always_comb begin
    valid_o = '0;
    entry_o = '0;
    seen    = 0;
    for (int unsigned i = 0; i < WPORT; i++) begin
      if (valid_i[i]) begin
        for (int unsigned j = 0; j < WPORT; j++) begin
          if (seen == j) begin
            valid_o[j]                 = 1'b1;
            entry_o[j*INDEX +: INDEX]  = entry_i[i*INDEX +: INDEX];
          end
        end
        seen = seen + 1;
      end
    end
    count_o = CNTW'(seen);
  end

endmodule

// File: rtl/iq_freelist_ctrl.sv
// Issue-queue free-list FIFO controller: owns head/tail/count, seeds the
// external free-list RAM with identity indices after reset and flush.
module iq_freelist_ctrl
  import iq_freelist_pkg::*;
#(
  parameter int unsigned RPORT = DEF_RPORT,
  parameter int unsigned WPORT = DEF_WPORT,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned INDEX = DEF_INDEX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic [RPORT-1:0]       alloc_req_i,
  output logic [RPORT*INDEX-1:0] alloc_entry_o,
  output logic                   stall_o,
  input  logic [WPORT-1:0]       free_valid_i,
  input  logic [WPORT*INDEX-1:0] free_entry_i,
  output logic [INDEX:0]         free_cnt_o,
  output logic                   ready_o,
  output logic                   error_o,
  output logic [RPORT*INDEX-1:0] ram_raddr_o,
  input  logic [RPORT*INDEX-1:0] ram_rdata_i,
  output logic [WPORT*INDEX-1:0] ram_waddr_o,
  output logic [WPORT*INDEX-1:0] ram_wdata_o,
  output logic [WPORT-1:0]       ram_we_o
);

  localparam int unsigned CW = INDEX + 1;
  localparam int unsigned SW = INDEX + 2;
  localparam int unsigned MW = $clog2(WPORT + 1);
  localparam int unsigned NW = $clog2(RPORT + 1);

  state_e           state_q, state_d;
  logic [INDEX-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    init_ptr_q, init_ptr_d;
  logic [CW-1:0]    free_cnt_q, free_cnt_d;
  logic             error_q, error_d;

  logic [WPORT-1:0]       dense_valid;
  logic [WPORT*INDEX-1:0] dense_entry;
  logic [MW-1:0]          free_num;
  logic [NW-1:0]          alloc_num;
  logic [NW-1:0]          alloc_eff;
  logic                   alloc_contig;
  logic [CW-1:0]          init_rem;
  logic [CW-1:0]          init_num;
  logic [SW-1:0]          cnt_sum;

  iq_freelist_compact #(
    .WPORT (WPORT),
    .INDEX (INDEX),
    .CNTW  (MW)
  ) u_compact (
    .valid_i (free_valid_i),
    .entry_i (free_entry_i),
    .valid_o (dense_valid),
    .entry_o (dense_entry),
    .count_o (free_num)
  );

  // Request decode: lane count, contiguity, and init burst size
  always_comb begin
    alloc_num = '0;
    for (int unsigned i = 0; i < RPORT; i++) begin
      alloc_num = alloc_num + NW'(alloc_req_i[i]);
    end
    alloc_contig = ((alloc_req_i & (alloc_req_i + RPORT'(1))) == '0);
    alloc_eff    = stall_o ? '0 : alloc_num;
    init_rem     = CW'(DEPTH) - init_ptr_q;
    init_num     = (init_rem < CW'(WPORT)) ? init_rem : CW'(WPORT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      head_q     <= '0;
      tail_q     <= '0;
      init_ptr_q <= '0;
      free_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      init_ptr_q <= init_ptr_d;
      free_cnt_q <= free_cnt_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    init_ptr_d = init_ptr_q;
    free_cnt_d = free_cnt_q;
    error_d    = error_q;
    cnt_sum    = '0;
    if (flush_i) begin
      state_d    = INIT;
      head_d     = '0;
      tail_d     = '0;
      init_ptr_d = '0;
      free_cnt_d = '0;
    end else begin
      case (state_q)
        INIT: begin
          init_ptr_d = init_ptr_q + init_num;
          free_cnt_d = free_cnt_q + init_num;
          if (init_ptr_d >= CW'(DEPTH)) begin
            state_d    = RUN;
            head_d     = '0;
            tail_d     = '0;
            free_cnt_d = CW'(DEPTH);
          end
        end
        RUN: begin
          if ((stall_o && (alloc_req_i != '0)) || !alloc_contig) begin
            error_d = 1'b1;
          end
          head_d  = head_q + INDEX'(alloc_eff);
          tail_d  = tail_q + INDEX'(free_num);
          cnt_sum = SW'(free_cnt_q) + SW'(free_num) - SW'(alloc_eff);
          // Overflow means a double free; clamp so the count stays meaningful
          if (cnt_sum > SW'(DEPTH)) begin
            error_d    = 1'b1;
            free_cnt_d = CW'(DEPTH);
          end else begin
            free_cnt_d = CW'(cnt_sum);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready_o     = (state_q == RUN);
    stall_o     = (state_q != RUN) || (free_cnt_q < CW'(RPORT));
    ram_we_o    = '0;
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    ram_raddr_o = '0;
    for (int unsigned j = 0; j < WPORT; j++) begin
      if (state_q == INIT) begin
        ram_waddr_o[j*INDEX +: INDEX] = INDEX'(init_ptr_q + CW'(j));
        ram_wdata_o[j*INDEX +: INDEX] = INDEX'(init_ptr_q + CW'(j));
        ram_we_o[j]                   = (CW'(j) < init_num);
      end else begin
        ram_waddr_o[j*INDEX +: INDEX] = tail_q + INDEX'(j);
        ram_wdata_o[j*INDEX +: INDEX] = dense_entry[j*INDEX +: INDEX];
        ram_we_o[j]                   = dense_valid[j];
      end
    end
    if (reset || flush_i) begin
      ram_we_o = '0;
    end
    for (int unsigned k = 0; k < RPORT; k++) begin
      ram_raddr_o[k*INDEX +: INDEX] = head_q + INDEX'(k);
    end
  end

  assign alloc_entry_o = ram_rdata_i;
  assign free_cnt_o    = free_cnt_q;
  assign error_o       = error_q;

endmodule

// File: doc/iq_freelist_ctrl.md
Name: iq_freelist_ctrl

Overview:
- Circular-FIFO controller for the issue-queue free list. It owns the head, tail and count of free IQ entry indices; the indices themselves live in a separate multi-port free-list RAM.
- Dispatch side: drives the RAM read addresses (RPORT lanes) and returns allocated IQ entry indices.
- Issue side: compacts the entries freed this cycle and drives the RAM write ports (WPORT lanes).
- The RAM has no reset, so this block fills it with the identity mapping after reset and after flush.

Parameters:
- RPORT, 4: dispatch/allocate lanes.
- WPORT, 4: issue/free lanes.
- DEPTH, 16: IQ entries. Must equal 2**INDEX.
- INDEX, 4: index/pointer width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush_i  in  1  pipeline recovery; every IQ entry becomes free
- alloc_req_i  in  RPORT  per-lane allocate request. Must be contiguous from lane 0.
- alloc_entry_o  out  RPORT*INDEX  lane k = ram_rdata lane k
- stall_o  out  1  dispatch must not request
- free_valid_i  in  WPORT  per-lane freed-entry valid (any pattern)
- free_entry_i  in  WPORT*INDEX  freed IQ indices
- free_cnt_o  out  INDEX+1  current free count
- ready_o  out  1  initialisation complete
- error_o  out  1  sticky protocol/overflow error
- ram_raddr_o  out  RPORT*INDEX  lane k = head+k
- ram_rdata_i  in  RPORT*INDEX  combinational read data
- ram_waddr_o  out  WPORT*INDEX  write addresses
- ram_wdata_o  out  WPORT*INDEX  write data
- ram_we_o  out  WPORT  write enables

Behaviour:
- Reset values (registered): head=0, tail=0, init_ptr=0, free_cnt=0, state=INIT, error_o=0. Resulting outputs: ready_o=0, stall_o=1, ram_we_o=0.
- Priority: reset > flush_i > normal operation.
- Pointers are INDEX bits and wrap naturally modulo DEPTH.

FSM states: INIT, RUN.

INIT:
- Each cycle write n=min(WPORT, DEPTH-init_ptr) entries: ram[init_ptr+j]=init_ptr+j, j<n.
- Each such cycle: init_ptr+=n, free_cnt+=n.
- When init_ptr reaches DEPTH: next cycle state=RUN, head=tail=0, free_cnt=DEPTH.
- Duration is ceil(DEPTH/WPORT) cycles (4 at defaults).
- alloc_req_i and free_valid_i are ignored in INIT. stall_o=1.

RUN:
- stall_o = (free_cnt < RPORT), decoded from the registered count.
- ram_raddr_o lane k = head+k every cycle; alloc_entry_o is combinational from ram_rdata_i.
- Allocate: n = popcount(alloc_req_i). The grant is implicit when stall_o=0; head+=n on the next edge.
- Free: m = popcount(free_valid_i). Valid lanes are compacted in lane order: the j-th valid lane writes ram[tail+j]. tail+=m; unused write ports have we=0.
- Count update: free_cnt_next = free_cnt + m - n.
- Same-cycle alloc and free: allocation reads old head slots before the write edge, and entries freed this cycle become allocatable next cycle. No bypass.
- Wrap: lanes crossing DEPTH-1 -> 0 behave identically to the non-wrapped case.

Errors (set error_o sticky until reset; the offending update is otherwise still applied):
- alloc_req_i nonzero while stall_o=1: allocation dropped, head unchanged.
- alloc_req_i not contiguous from lane 0.
- free_cnt + m - n > DEPTH: the count saturates at DEPTH.

flush_i:
- Next cycle: state=INIT, init_ptr=0, free_cnt=0, ready_o=0. Same-cycle alloc/free ignored.
- Flush during INIT restarts init from 0.

Decomposition:
- Package iq_freelist_pkg: RPORT/WPORT/DEPTH/INDEX defaults, iq_idx_t (INDEX bits), cnt_t (INDEX+1 bits), state enum {INIT, RUN}.
- Sub-module iq_freelist_compact: combinational prefix-sum compaction of free_valid_i/free_entry_i into dense write-port lanes, with popcount output.

Test Plan (defaults):
1. Reset 1 cycle -> 4 INIT cycles writing ram[0..15]=0..15 (4 per cycle, ram_we_o=4'b1111). Cycle 5: ready_o=1, free_cnt_o=16, stall_o=0.
2. After init, alloc_req_i=4'b1111 -> alloc_entry_o={3,2,1,0}, next cycle head=4, free_cnt_o=12.
3. Then free_valid_i=4'b1010 with entries lane1=2, lane3=0 -> ram[0]=2, ram[1]=0 via ports 0/1 only, tail=2, free_cnt_o=14. The same cycle with alloc_req_i=4'b0011 -> free_cnt_o=12.
4. Allocate repeatedly until free_cnt_o=3 -> stall_o=1. alloc_req_i=4'b0001 while stalled -> error_o=1, head unchanged.
5. Wrap: head=14, alloc 4 -> ram_raddr_o={1,0,15,14}, next cycle head=2.
6. Assert flush_i mid-RUN -> next cycle ready_o=0; re-init 4 cycles; free_cnt_o=16, head=tail=0. A second flush during cycle 2 of INIT -> init restarts, total 4 more cycles.
